// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for a small RV32-style core.
// Walks each instruction through FETCH, DECODE, EXEC, optional MEM and WB,
// and decodes the datapath enables from the registered state and the opcode.
// Optional feature macro: CPU_SEQ_TRAP_EN. It adds the TRAP state, which is
// entered on an unknown opcode or on a data-memory wait timeout.
// Without the macro, unknown opcodes retire as NOPs and MEM waits indefinitely.
//
// Memory handshake: while in MEM the sequencer holds dm_read_en or
// dm_write_en high every cycle. The access completes in the first MEM cycle
// that samples mem_ready=1, and that cycle is the last one with the enable
// asserted. mem_ready is ignored outside MEM.
module cpu_sequencer #(
   parameter int unsigned MEM_WAIT_MAX = 15
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       ir_load,
   output logic       reg_read_en,
   output logic       reg_write_en,
   output logic       dm_read_en,
   output logic       dm_write_en,
   output logic       pc_write_en,
   output logic       pc_sel,
   output logic       alu_a_sel,
   output logic       alu_b_sel,
   output logic       instr_retired,
   output logic       trap,
   output logic [1:0] wb_sel,
   output logic [2:0] state
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_EXEC   = 3'd3;
   localparam logic [2:0] S_MEM    = 3'd4;
   localparam logic [2:0] S_WB     = 3'd5;
   localparam logic [2:0] S_TRAP   = 3'd6;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_FENCE  = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   logic [2:0] state_q;
   logic [2:0] state_d;
   logic       is_load, is_store, is_op, is_opimm, is_lui, is_auipc;
   logic       is_jal, is_jalr, is_branch, is_fence, is_system;
   logic       is_known, is_jump, exec_retire, exec_trap, mem_timeout;
   logic [2:0] next_instr;

   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_op     = (opcode == OPC_OP);
   assign is_opimm  = (opcode == OPC_OPIMM);
   assign is_lui    = (opcode == OPC_LUI);
   assign is_auipc  = (opcode == OPC_AUIPC);
   assign is_jal    = (opcode == OPC_JAL);
   assign is_jalr   = (opcode == OPC_JALR);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_fence  = (opcode == OPC_FENCE);
   assign is_system = (opcode == OPC_SYSTEM);
   assign is_jump   = is_jal | is_jalr;
   assign is_known  = is_load | is_store | is_op | is_opimm | is_lui | is_auipc |
                      is_jump | is_branch | is_fence | is_system;

   // Run is only looked at when an instruction finishes.
   assign next_instr = run ? S_FETCH : S_IDLE;
   assign state      = state_q;

`ifdef CPU_SEQ_TRAP_EN
   localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

   logic [7:0] wait_cnt;

   // Unknown opcodes trap instead of retiring.
   assign exec_retire = is_branch | is_fence | is_system;
   assign exec_trap   = ~is_known;
   // This MEM cycle is the MEM_WAIT_MAX-th one without mem_ready.
   assign mem_timeout = (wait_cnt == WAIT_LAST);
   assign trap        = (state_q == S_TRAP);

   // Count consecutive MEM cycles without mem_ready. The count is zero on MEM entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         wait_cnt <= '0;
      end else if (state_q == S_MEM && !mem_ready && !mem_timeout) begin
         wait_cnt <= wait_cnt + 8'd1;
      end else begin
         wait_cnt <= '0;
      end
   end
`else
   logic unused_wait_max;

   // Unknown opcodes take the short retire path as a NOP.
   assign exec_retire     = is_branch | is_fence | is_system | ~is_known;
   assign exec_trap       = 1'b0;
   assign mem_timeout     = 1'b0;
   assign trap            = 1'b0;
   assign unused_wait_max = (MEM_WAIT_MAX == 0);
`endif

   // State register; reset wins over everything, including a pending MEM access.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:   if (run) state_d = S_FETCH;
         S_FETCH:  state_d = S_DECODE;
         S_DECODE: state_d = S_EXEC;
         S_EXEC: begin
            if (exec_trap)                state_d = S_TRAP;
            else if (is_load || is_store) state_d = S_MEM;
            else if (exec_retire)         state_d = next_instr;
            else                          state_d = S_WB;
         end
         S_MEM: begin
            if (mem_ready)        state_d = is_load ? S_WB : next_instr;
            else if (mem_timeout) state_d = S_TRAP;
         end
         S_WB:     state_d = next_instr;
         S_TRAP:   state_d = S_TRAP;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath enables decoded from state, opcode, branch_taken and mem_ready.
   always_comb begin
      ir_load       = 1'b0;
      reg_read_en   = 1'b0;
      reg_write_en  = 1'b0;
      dm_read_en    = 1'b0;
      dm_write_en   = 1'b0;
      pc_write_en   = 1'b0;
      pc_sel        = 1'b0;
      alu_a_sel     = 1'b0;
      alu_b_sel     = 1'b0;
      instr_retired = 1'b0;
      wb_sel        = 2'b00;
      case (state_q)
         S_FETCH:  ir_load     = 1'b1;
         S_DECODE: reg_read_en = 1'b1;
         S_EXEC: begin
            alu_a_sel = is_auipc | is_jal | is_branch;
            alu_b_sel = ~(is_op | is_branch);
            if (exec_retire) begin
               pc_write_en   = 1'b1;
               pc_sel        = is_branch & branch_taken;
               instr_retired = 1'b1;
            end
         end
         S_MEM: begin
            dm_read_en  = is_load;
            dm_write_en = ~is_load;
            if (mem_ready && !is_load) begin
               pc_write_en   = 1'b1;
               instr_retired = 1'b1;
            end
         end
         S_WB: begin
            reg_write_en  = 1'b1;
            pc_write_en   = 1'b1;
            pc_sel        = is_jump;
            instr_retired = 1'b1;
            if (is_load)      wb_sel = 2'b01;
            else if (is_jump) wb_sel = 2'b10;
         end
         default: ;
      endcase
   end

endmodule
